// File: rtl/fcpu_pkg.sv
// Shared types and constants for the fcpu result path.
//   RSV_ID_W    - reservation-station tag width
//   DATA_W      - result data width
//   N_CDB_SRC_W - log2 of the number of CDB result sources
//   cdb_t       - one CDB result: {tag, data}
//   CDB_W       - packed width of cdb_t
package fcpu_pkg;

    localparam int RSV_ID_W    = 5;
    localparam int DATA_W      = 32;
    localparam int N_CDB_SRC_W = 2;

    typedef struct packed {
        logic [RSV_ID_W-1:0] tag;
        logic [DATA_W-1:0]   data;
    } cdb_t;

    localparam int CDB_W = $bits(cdb_t);

endpackage

// File: rtl/fcpu_cdb_fifo2.sv
// Two-entry FIFO of CDB results for a single source.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   flush      - synchronous clear of all entries (wins over push/pop)
//   push, din  - write one entry (ignored when full)
//   pop        - remove the head entry (ignored when empty)
//   head       - oldest entry, valid while count != 0
//   count      - number of stored entries (0..2)
// Storage is a two-slot shift structure: slot0 is always the head, so a pop
// moves slot1 down and the read side needs no pointer.
module fcpu_cdb_fifo2
    import fcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_t       din,
    output cdb_t       head,
    output logic [1:0] count
);

    cdb_t slot0;
    cdb_t slot1;
    logic push_ok;
    logic pop_ok;

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && (count != 2'd0);
    assign head    = slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is 1 here (push_ok excludes 2, pop_ok excludes 0).
                    slot0 <= din;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fcpu_cdb_arbiter.sv
// Common-data-bus transmitter. Buffers completed results from N_SRC
// functional units (two entries each) and broadcasts one result per cycle,
// choosing among non-empty buffers round-robin.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   flush      - discard every buffered and outgoing result
//   src_valid  - per-source result valid          [N_SRC]
//   src_ready  - per-source buffer has space      [N_SRC]
//   src_tag    - per-source tag, source 0 in LSBs [N_SRC*RSV_ID_W]
//   src_data   - per-source data, source 0 in LSBs[N_SRC*DATA_W]
//   cdb_valid  - broadcast valid (exactly one cycle per result)
//   cdb_tag    - broadcast tag
//   cdb_data   - broadcast data
//   cdb_src    - index of the source that produced the broadcast
// Handshake: a source result transfers on a rising edge where
// src_valid[i] && src_ready[i]; the source holds tag/data stable until then.
// The CDB side has no backpressure.
module fcpu_cdb_arbiter #(
    parameter int N_SRC_W  = fcpu_pkg::N_CDB_SRC_W,
    parameter int RSV_ID_W = fcpu_pkg::RSV_ID_W,
    parameter int DATA_W   = fcpu_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [(1<<N_SRC_W)-1:0]    src_valid,
    output logic [(1<<N_SRC_W)-1:0]    src_ready,
    input  logic [(1<<N_SRC_W)*RSV_ID_W-1:0] src_tag,
    input  logic [(1<<N_SRC_W)*DATA_W-1:0]   src_data,
    output logic                       cdb_valid,
    output logic [RSV_ID_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [N_SRC_W-1:0]         cdb_src
);

    localparam int N_SRC = 1 << N_SRC_W;

    fcpu_pkg::cdb_t       head [N_SRC];
    logic [1:0]           count [N_SRC];
    logic [N_SRC-1:0]     push;
    logic [N_SRC-1:0]     pop;
    logic                 ready_en;
    logic [N_SRC_W-1:0]   rr;
    logic                 grant_valid;
    logic [N_SRC_W-1:0]   grant_idx;
    fcpu_pkg::cdb_t       grant_head;

    // ready_en keeps every buffer closed while reset is held and opens
    // them on the first edge after release.
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        fcpu_pkg::cdb_t din;

        assign din.tag      = src_tag[i*RSV_ID_W +: RSV_ID_W];
        assign din.data     = src_data[i*DATA_W +: DATA_W];
        assign src_ready[i] = ready_en && (count[i] != 2'd2);
        assign push[i]      = src_valid[i] && src_ready[i];
        assign pop[i]       = grant_valid && (grant_idx == N_SRC_W'(i));

        fcpu_cdb_fifo2 u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din),
            .head  (head[i]),
            .count (count[i])
        );
    end

    // Round-robin search starting at rr. Scanning offsets from high to low
    // lets the smallest offset with a non-empty buffer overwrite the rest.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = N_SRC - 1; off >= 0; off--) begin
            logic [N_SRC_W-1:0] cand;
            cand = rr + N_SRC_W'(off);
            if (count[cand] != 2'd0) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_head = head[grant_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            rr        <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                // The grant of this cycle is dropped and rr stays put.
                cdb_valid <= 1'b0;
            end else if (grant_valid) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= grant_head.tag;
                cdb_data  <= grant_head.data;
                cdb_src   <= grant_idx;
                rr        <= grant_idx + 1'b1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fcpu_cdb_arbiter.sv
// Self-checking bench for fcpu_cdb_arbiter: directed scenarios scored
// against an expected-broadcast queue, plus a traffic driver with per-source
// expected queues and an occupancy model for ready and throughput.
module tb_fcpu_cdb_arbiter;

    localparam int NS = 4;
    localparam int TW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_ready;
    logic [NS*TW-1:0] src_tag;
    logic [NS*DW-1:0] src_data;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      cdb_src;

    int n_checks = 0;
    int n_fail   = 0;

    // Directed scoreboard entry: {src, tag, data}
    logic [2+TW+DW-1:0] exp_q[$];
    // Per-source scoreboard entry: {tag, data}
    logic [TW+DW-1:0]   src_q[NS][$];
    logic [1:0]         src_log[$];

    fcpu_cdb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, then score whatever the CDB shows against exp_q.
    task automatic tick_and_score();
        logic [2+TW+DW-1:0] e;
        tick();
        if (exp_q.size() == 0) begin
            check("spurious_bcast", cdb_valid, 0);
        end else if (cdb_valid) begin
            e = exp_q.pop_front();
            check("bcast", {cdb_src, cdb_tag, cdb_data}, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_src(input int s, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        src_valid[s]          = 1'b1;
        src_tag[s*TW +: TW]   = tag;
        src_data[s*DW +: DW]  = data;
    endtask

    task automatic do_reset();
        src_valid = '0;
        flush     = 1'b0;
        #2 rst_n  = 1'b0;
        tick();
        tick();
        #3 rst_n  = 1'b1;
        tick();
        exp_q.delete();
    endtask

    // Streams n_items results on each source in mask, holding each result
    // until accepted. Tracks per-source occupancy independently to check
    // ready and the one-broadcast-per-cycle rule.
    task automatic run_traffic(input logic [NS-1:0] mask, input int n_items,
                               input bit rand_gap, input bit log_src);
        int left [NS];
        int occ  [NS];
        logic [NS-1:0] rdy;
        logic [TW+DW-1:0] got;
        bit pend;
        bit busy;
        int budget;
        int s;
        for (int i = 0; i < NS; i++) begin
            left[i] = mask[i] ? n_items : 0;
            occ[i]  = 0;
        end
        src_valid = '0;
        budget    = 0;
        busy      = 1'b1;
        while (busy && budget < 2000) begin
            for (int i = 0; i < NS; i++) begin
                if (!src_valid[i] && left[i] > 0 && (!rand_gap || $urandom_range(0, 2) != 0))
                    set_src(i, TW'($urandom_range(0, 31)), $urandom);
            end
            rdy  = src_ready;
            pend = 1'b0;
            for (int i = 0; i < NS; i++) if (occ[i] > 0) pend = 1'b1;
            tick();
            budget++;
            check("throughput", cdb_valid, pend);
            if (cdb_valid) begin
                s = int'(cdb_src);
                if (log_src) src_log.push_back(cdb_src);
                if (src_q[s].size() == 0) begin
                    check("bcast_no_pending", 1, 0);
                end else begin
                    got = src_q[s].pop_front();
                    check("src_order", {cdb_tag, cdb_data}, got);
                    occ[s]--;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && rdy[i]) begin
                    src_q[i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
                    occ[i]++;
                    left[i]--;
                    src_valid[i] = 1'b0;
                end
            end
            for (int i = 0; i < NS; i++)
                check("ready", src_ready[i], (occ[i] < 2) ? 1 : 0);
            busy = 1'b0;
            for (int i = 0; i < NS; i++) if (left[i] > 0 || occ[i] > 0) busy = 1'b1;
        end
        check("traffic_done_in_budget", busy, 0);
        src_valid = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;

        // Reset state
        tick();
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_data", cdb_data, 0);
        check("rst_cdb_src", cdb_src, 0);
        check("rst_src_ready", src_ready, 4'h0);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_ready", src_ready, 4'hf);

        // 1: single result, two-edge latency, one-cycle broadcast
        set_src(0, 5'd3, 32'h11);
        exp_q.push_back({2'd0, 5'd3, 32'h11});
        tick_and_score();
        src_valid = '0;
        check("t1_no_bypass", cdb_valid, 0);
        tick_and_score();
        check("t1_valid", cdb_valid, 1);
        tick_and_score();
        check("t1_one_cycle", cdb_valid, 0);
        check("t1_tag_hold", cdb_tag, 5'd3);
        check("t1_drained", exp_q.size(), 0);

        // 2: all four sources on one edge, rr=0
        do_reset();
        for (int i = 0; i < NS; i++) begin
            set_src(i, TW'(i + 1), 32'h100 + i);
            exp_q.push_back({2'(i), 5'(i + 1), 32'h100 + i});
        end
        tick_and_score();
        src_valid = '0;
        check("t2_no_bypass", cdb_valid, 0);
        for (int i = 0; i < NS; i++) begin
            tick_and_score();
            check("t2_valid", cdb_valid, 1);
            check("t2_src", cdb_src, i);
        end
        tick_and_score();
        check("t2_idle", cdb_valid, 0);
        // rr should be back at 0: src0 beats src1
        set_src(1, 5'd21, 32'hbeef0001);
        set_src(0, 5'd20, 32'hbeef0000);
        exp_q.push_back({2'd0, 5'd20, 32'hbeef0000});
        exp_q.push_back({2'd1, 5'd21, 32'hbeef0001});
        tick_and_score();
        src_valid = '0;
        for (int i = 0; i < 3; i++) tick_and_score();
        check("t2_rr_drained", exp_q.size(), 0);

        // 3: src2 back-to-back results alone
        do_reset();
        run_traffic(4'b0100, 3, 1'b0, 1'b0);

        // 4: continuous traffic on src0 and src3 alternates
        do_reset();
        src_log.delete();
        run_traffic(4'b1001, 4, 1'b0, 1'b1);
        check("t4_count", src_log.size(), 8);
        for (int i = 0; i < src_log.size(); i++)
            check("t4_alternate", src_log[i], (i % 2 == 0) ? 0 : 3);

        // 5: flush with src1 full and a concurrent src0 push
        do_reset();
        set_src(0, 5'd5, 32'ha0);
        set_src(1, 5'd6, 32'ha1);
        exp_q.push_back({2'd0, 5'd5, 32'ha0});
        tick_and_score();
        src_valid[0] = 1'b0;
        set_src(1, 5'd7, 32'ha2);
        check("t5_ready_half", src_ready, 4'hf);
        tick_and_score();
        check("t5_src0_bcast", cdb_valid, 1);
        check("t5_src1_full", src_ready[1], 0);
        check("t5_src0_ready", src_ready[0], 1);
        src_valid = '0;
        flush     = 1'b1;
        set_src(0, 5'd9, 32'hb0);
        tick_and_score();
        flush     = 1'b0;
        src_valid = '0;
        check("t5_flush_no_bcast", cdb_valid, 0);
        check("t5_ready_after_flush", src_ready, 4'hf);
        for (int i = 0; i < 4; i++) tick_and_score();

        // 6: asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < NS; i++) set_src(i, TW'(i + 10), 32'hc0 + i);
        tick();
        src_valid = '0;
        tick();
        check("t6_busy_before", cdb_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", cdb_valid, 0);
        check("t6_async_ready", src_ready, 4'h0);
        check("t6_async_tag", cdb_tag, 0);
        exp_q.delete();
        tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick_and_score();
        check("t6_ready_back", src_ready, 4'hf);

        // Random traffic on all sources
        do_reset();
        run_traffic(4'hf, 12, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        check("watchdog_timeout", 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
